// File: rtl/hearing_aid_pkg.sv
// Shared constants and types for the hearing-aid audio path (Q1.15 samples).
// Holds the compressor stage state encoding and the sample saturation helper.
package hearing_aid_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DIV_STEPS = 16;

  localparam logic [SAMPLE_W-1:0]        UNITY_Q15  = 16'd32767;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENV,
    S_DIV,
    S_APPLY,
    S_OUT
  } comp_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [31:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 32'sd32767) begin
      r = SAMPLE_MAX;
    end else if (v < -32'sd32768) begin
      r = SAMPLE_MIN;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dynamic_range_compressor_stage_if.sv
// Audio sample stream: one-cycle valid strobe qualifying a signed Q1.15 sample.
// No backpressure; the sink flags samples it cannot take.
interface dynamic_range_compressor_stage_if;
  import hearing_aid_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_dat;
  logic                       sample_vld;

  modport master (output sample_dat, sample_vld);
  modport slave  (input  sample_dat, sample_vld);

endinterface

// File: rtl/seq_divider_if.sv
// Start/done handshake between the compressor FSM and its sequential divider.
// start is a one-cycle pulse; done pulses once the quotient is final.
interface seq_divider_if;
  import hearing_aid_pkg::*;

  logic                start;
  logic [SAMPLE_W-1:0] rem_init;
  logic [SAMPLE_W-1:0] dividend;
  logic [SAMPLE_W-1:0] divisor;
  logic [SAMPLE_W-1:0] quotient;
  logic                done;

  modport master (output start, rem_init, dividend, divisor, input  quotient, done);
  modport slave  (input  start, rem_init, dividend, divisor, output quotient, done);

endinterface

// File: rtl/seq_divider.sv
// Restoring divider of {rem_init,dividend} by divisor, one quotient bit per cycle.
// Fixed 16 cycles start->done; no backpressure, a new start restarts it; needs rem_init < divisor.
module seq_divider
  import hearing_aid_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave div
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  logic [SAMPLE_W-1:0] r_rem;
  logic [SAMPLE_W-1:0] r_dvd;
  logic [SAMPLE_W-1:0] r_dvs;
  logic [SAMPLE_W-1:0] r_quo;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;

  logic [SAMPLE_W-1:0] w_rem_src;
  logic [SAMPLE_W-1:0] w_dvd_src;
  logic [SAMPLE_W-1:0] w_dvs_src;
  logic [SAMPLE_W-1:0] w_quo_src;
  logic [SAMPLE_W:0]   w_trial;
  logic                w_fits;
  logic [SAMPLE_W-1:0] w_rem_nxt;
  logic [SAMPLE_W-1:0] w_dvd_nxt;
  logic [SAMPLE_W-1:0] w_quo_nxt;

  // The start cycle already performs the first iteration straight from the operands.
  always_comb begin
    w_rem_src = r_rem;
    w_dvd_src = r_dvd;
    w_dvs_src = r_dvs;
    w_quo_src = r_quo;
    if (div.start) begin
      w_rem_src = div.rem_init;
      w_dvd_src = div.dividend;
      w_dvs_src = div.divisor;
      w_quo_src = '0;
    end
    w_trial   = {w_rem_src, w_dvd_src[SAMPLE_W-1]};
    w_fits    = (w_trial >= {1'b0, w_dvs_src});
    w_rem_nxt = w_fits ? SAMPLE_W'(w_trial - {1'b0, w_dvs_src}) : w_trial[SAMPLE_W-1:0];
    w_quo_nxt = {w_quo_src[SAMPLE_W-2:0], w_fits};
    w_dvd_nxt = {w_dvd_src[SAMPLE_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (div.start || r_busy) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_dvd_nxt;
        r_quo <= w_quo_nxt;
        if (div.start) begin
          r_dvs  <= div.divisor;
          r_cnt  <= CNT_W'(1);
          r_busy <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign div.quotient = r_quo;
  assign div.done     = r_done;

endmodule

// File: rtl/dynamic_range_compressor_stage.sv
// Feed-forward compressor: envelope follower, knee/ratio gain via sequential divide, Q1.15 apply.
// Fixed latency: accept edge N -> audio_ready after edge N+19; no backpressure, busy arrivals set overrun.
module dynamic_range_compressor_stage
  import hearing_aid_pkg::*;
#(
  parameter int THRESHOLD     = 8192,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int RATIO_SHIFT   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  input  logic                       audio_valid,
  output logic signed [SAMPLE_W-1:0] audio_out,
  output logic                       audio_ready,
  output logic                       overrun
);

  localparam logic [SAMPLE_W-1:0] THR = SAMPLE_W'(THRESHOLD);

  comp_state_t                r_state;
  comp_state_t                w_state_nxt;
  logic signed [SAMPLE_W-1:0] r_x;
  logic [SAMPLE_W-1:0]        r_env;
  logic signed [SAMPLE_W-1:0] r_result;
  logic signed [SAMPLE_W-1:0] r_out;
  logic                       r_ready;
  logic                       r_overrun;

  logic                       w_accept;
  logic                       w_drop;
  logic [SAMPLE_W-1:0]        w_mag;
  logic [SAMPLE_W-1:0]        w_env_nxt;
  logic [SAMPLE_W-1:0]        w_num;
  logic [SAMPLE_W-1:0]        w_gain;
  logic signed [31:0]         w_x_ext;
  logic signed [31:0]         w_gain_ext;

  seq_divider_if u_div_if ();

  seq_divider u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (u_div_if)
  );

  assign w_accept = (r_state == S_IDLE) && audio_valid;
  assign w_drop   = (r_state != S_IDLE) && audio_valid;

  // |x| with -32768 folded onto 32767 so the envelope stays within 15 bits.
  always_comb begin
    w_mag = r_x;
    if (r_x == SAMPLE_MIN) begin
      w_mag = SAMPLE_MAX;
    end else if (r_x[SAMPLE_W-1]) begin
      w_mag = -r_x;
    end
  end

  always_comb begin
    w_env_nxt = r_env;
    if (w_mag > r_env) begin
      w_env_nxt = r_env + ((w_mag - r_env) >> ATTACK_SHIFT);
    end else begin
      w_env_nxt = r_env - ((r_env - w_mag) >> RELEASE_SHIFT);
    end
  end

  // num <= env always holds, so (num<<15)/env fits 16 quotient bits.
  always_comb begin
    w_num = w_env_nxt;
    if (w_env_nxt > THR) begin
      w_num = THR + ((w_env_nxt - THR) >> RATIO_SHIFT);
    end
  end

  // The divide is launched from ENV using the envelope being written this cycle.
  assign u_div_if.start    = (r_state == S_ENV);
  assign u_div_if.rem_init = {1'b0, w_num[SAMPLE_W-1:1]};
  assign u_div_if.dividend = {w_num[0], {(SAMPLE_W-1){1'b0}}};
  assign u_div_if.divisor  = w_env_nxt;

  always_comb begin
    w_gain = UNITY_Q15;
    if (r_env > THR) begin
      w_gain = (u_div_if.quotient > UNITY_Q15) ? UNITY_Q15 : u_div_if.quotient;
    end
  end

  assign w_x_ext    = 32'(r_x);
  assign w_gain_ext = {16'b0, w_gain};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (audio_valid) w_state_nxt = S_ENV;
      S_ENV:   w_state_nxt = S_DIV;
      S_DIV:   if (u_div_if.done) w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_env     <= '0;
      r_result  <= '0;
      r_out     <= '0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (r_state == S_OUT);
      if (w_accept) begin
        r_x <= audio_in;
      end
      if (r_state == S_ENV) begin
        r_env <= w_env_nxt;
      end
      if (r_state == S_APPLY) begin
        r_result <= sat_sample((w_x_ext * w_gain_ext) >>> 15);
      end
      if (r_state == S_OUT) begin
        r_out <= r_result;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign audio_out   = r_out;
  assign audio_ready = r_ready;
  assign overrun     = r_overrun;

endmodule

// File: doc/dynamic_range_compressor_stage.md
DYNAMIC_RANGE_COMPRESSOR_STAGE -- requirements
Module: dynamic_range_compressor_stage

Interface
REQ-001 SHALL have parameter THRESHOLD, default 8192, compression knee on envelope magnitude (unsigned, 1..32767).
REQ-002 SHALL have parameter ATTACK_SHIFT, default 2, envelope rise smoothing shift.
REQ-003 SHALL have parameter RELEASE_SHIFT, default 6, envelope fall smoothing shift.
REQ-004 SHALL have parameter RATIO_SHIFT, default 2, above-knee slope = 1/2^RATIO_SHIFT.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port audio_in, input, signed 16, sample from the upstream processor output.
REQ-008 SHALL have port audio_valid, input, 1, one-cycle strobe qualifying audio_in (driven by upstream audio_ready).
REQ-009 SHALL have port audio_out, output, signed 16, compressed sample, held between strobes.
REQ-010 SHALL have port audio_ready, output, 1, one-cycle strobe qualifying audio_out.
REQ-011 SHALL have port overrun, output, 1, sticky flag: a sample arrived while busy.

Function
REQ-012 SHALL implement FSM IDLE -> ENV -> DIV -> APPLY -> OUT -> IDLE.
REQ-013 IDLE: audio_valid=1 latches audio_in, next state ENV; otherwise stays IDLE.
REQ-014 ENV (1 cycle): mag=|x|, with -32768 mapped to 32767; if mag>env, env += (mag-env)>>ATTACK_SHIFT, else env -= (env-mag)>>RELEASE_SHIFT; env is 16-bit unsigned, never exceeds 32767.
REQ-015 DIV (exactly 16 cycles): if env<=THRESHOLD, gain=32767 and the divider result is ignored; else num=THRESHOLD+((env-THRESHOLD)>>RATIO_SHIFT) and gain=(num<<15)/env via a 16-iteration restoring divider, clamped to 32767.
REQ-016 APPLY (1 cycle): prod = x*gain (32-bit signed); result = prod>>>15, truncating toward -inf, saturated to [-32768,32767].
REQ-017 OUT (1 cycle): audio_out <= result, audio_ready=1 for exactly this cycle.
REQ-018 Latency SHALL be fixed: sample accepted at edge N produces audio_ready high in the cycle after edge N+19, independent of data.
REQ-019 Any audio_valid=1 sampled outside IDLE SHALL drop that sample and set overrun=1; in-flight sample unaffected.
REQ-020 audio_valid in the OUT cycle SHALL count as overrun (no same-cycle re-accept).
REQ-021 env SHALL persist across samples; it is only cleared by reset.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, env=0, audio_out=0, audio_ready=0, overrun=0, divider cleared.
REQ-023 Reset mid-operation SHALL abandon the in-flight sample; no audio_ready pulse for it after release.
REQ-024 First audio_valid accepted is the one sampled on the first edge with rst_n high.

Structure
REQ-025 Shared package hearing_aid_pkg SHALL hold sample width (16), Q1.15 unity constant (32767), and the compressor state enum.
REQ-026 Division SHALL live in sub-module seq_divider (16-bit unsigned restoring, start/done handshake, fixed 16 cycles).
REQ-027 Stage SHALL be instantiable directly downstream of the hearing-aid processor top, audio_ready -> audio_valid.

Verification (default parameters)
REQ-028 Reset: hold rst_n low, toggle audio_valid -> audio_out=0, audio_ready=0, overrun=0 throughout.
REQ-029 Below knee: single audio_in=1000 from reset -> audio_out=999, audio_ready high exactly 19 cycles after accept edge, 1 cycle wide.
REQ-030 Loud steady: 200 samples of 32767 spaced 25 cycles -> final audio_out within [14320,14345], never above 32767.
REQ-031 Overrun: valid=1000 at cycle N, valid=2000 at N+5 -> one audio_ready pulse, audio_out=999, overrun=1 until reset.
REQ-032 Reset mid-DIV: accept sample at N, rst_n low at N+8 -> no audio_ready pulse, env=0, next sample after release behaves as REQ-029.
REQ-033 Negative full scale: audio_in=-32768 from reset -> audio_out=-32767, no saturation wrap.
